// File: rtl/skeleton_ram_driver.sv
// On-device initiator for the RAM test skeleton: header check, pattern write,
// read-back compare, and pass/fail reporting with error count and first failing address.
module skeleton_ram_driver #(
    parameter int BITWIDTH_IN  = 12,
    parameter int BITWIDTH_SYS = 16,
    parameter int BITWIDTH_ADR = 6,
    parameter int READ_LAT     = 1
) (
    input  logic                    CLK_SYS,
    input  logic                    RSTN,
    input  logic                    START,
    input  logic [1:0]              MODE,
    input  logic [BITWIDTH_IN-1:0]  SEED,
    output logic                    RAM_EN,
    output logic                    RAM_RnW,
    output logic [BITWIDTH_ADR-1:0] RAM_ADR,
    output logic [BITWIDTH_SYS-1:0] RAM_DIN,
    input  logic [BITWIDTH_SYS-1:0] RAM_DOUT,
    input  logic                    RAM_RDY,
    input  logic [25:0]             RAM_HEAD,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    PASS,
    output logic                    HEAD_ERR,
    output logic [BITWIDTH_ADR:0]   ERR_CNT,
    output logic [BITWIDTH_ADR-1:0] FIRST_ERR_ADR
);

    // state      | meaning
    // S_IDLE     | waiting for START; result outputs hold
    // S_CHECK_HEAD | compare skeleton DATA_HEAD against this build's geometry
    // S_WRITE    | issue one pattern write per RDY-high cycle
    // S_READ     | issue one read per RDY-high cycle, push into compare pipe
    // S_DRAIN    | let in-flight reads reach the comparator
    // S_FINISH   | result valid for one cycle before returning to idle
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK_HEAD, S_WRITE, S_READ, S_DRAIN, S_FINISH
    } state_t;

    localparam int PAD   = BITWIDTH_SYS - BITWIDTH_IN;
    localparam int EXT_W = (BITWIDTH_ADR < BITWIDTH_IN) ? BITWIDTH_ADR : BITWIDTH_IN;
    localparam logic [25:0] EXP_HEAD = {4'd4, 6'(BITWIDTH_ADR), 6'(BITWIDTH_ADR),
                                        5'(BITWIDTH_IN), 5'(BITWIDTH_IN)};

    function automatic logic [BITWIDTH_SYS-1:0] pattern_word(
        input logic [1:0]              mode,
        input logic [BITWIDTH_IN-1:0]  seed,
        input logic [BITWIDTH_ADR-1:0] adr
    );
        logic [BITWIDTH_IN-1:0] ext;
        logic [BITWIDTH_IN-1:0] pat;
        ext = '0;
        pat = '0;
        for (int i = 0; i < EXT_W; i++) ext[i] = adr[i];
        case (mode)
            2'd0: pat = ext;
            2'd1: pat = ~ext;
            2'd2: for (int i = 0; i < BITWIDTH_IN; i++) pat[i] = adr[0] ^ 1'(i % 2);
            default: pat = seed + ext;
        endcase
        return BITWIDTH_SYS'(pat) << PAD;
    endfunction

    state_t                  state_q;
    logic [BITWIDTH_ADR-1:0] addr_q;
    logic [BITWIDTH_ADR-1:0] adr_hold_q;
    logic [BITWIDTH_SYS-1:0] din_hold_q;
    logic [1:0]              mode_q;
    logic [BITWIDTH_IN-1:0]  seed_q;
    logic                    busy_q, done_q, pass_q, head_err_q;
    logic [BITWIDTH_ADR:0]   err_cnt_q, err_cnt_d;
    logic [BITWIDTH_ADR-1:0] first_err_q;
    logic [READ_LAT-1:0]     pipe_v_q;
    logic [BITWIDTH_ADR-1:0] pipe_a_q [READ_LAT];

    logic                    issue, is_write, cmp_v, mismatch, pipe_busy;
    logic [BITWIDTH_ADR-1:0] cmp_a;
    logic [BITWIDTH_SYS-1:0] cur_din;

    assign is_write  = (state_q == S_WRITE);
    assign issue     = ((state_q == S_WRITE) || (state_q == S_READ)) && RAM_RDY;
    assign cur_din   = pattern_word(mode_q, seed_q, addr_q);
    assign cmp_v     = pipe_v_q[READ_LAT-1];
    assign cmp_a     = pipe_a_q[READ_LAT-1];
    assign mismatch  = cmp_v && (RAM_DOUT != pattern_word(mode_q, seed_q, cmp_a));
    assign err_cnt_d = err_cnt_q + {{BITWIDTH_ADR{1'b0}}, mismatch};

    // Stages other than the comparator stage still holding data keep DRAIN waiting.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < READ_LAT - 1; i++) pipe_busy = pipe_busy | pipe_v_q[i];
    end

    assign RAM_EN        = issue;
    assign RAM_RnW       = is_write;
    assign RAM_ADR       = issue ? addr_q : adr_hold_q;
    assign RAM_DIN       = (issue && is_write) ? cur_din : din_hold_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign PASS          = pass_q;
    assign HEAD_ERR      = head_err_q;
    assign ERR_CNT       = err_cnt_q;
    assign FIRST_ERR_ADR = first_err_q;

    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            pipe_v_q <= '0;
            for (int i = 0; i < READ_LAT; i++) pipe_a_q[i] <= '0;
        end else begin
            pipe_v_q[0] <= issue && (state_q == S_READ);
            pipe_a_q[0] <= addr_q;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_a_q[i] <= pipe_a_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            adr_hold_q  <= '0;
            din_hold_q  <= '0;
            mode_q      <= '0;
            seed_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            head_err_q  <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (mismatch && (err_cnt_q == '0)) first_err_q <= cmp_a;
            if (issue) begin
                adr_hold_q <= addr_q;
                addr_q     <= addr_q + BITWIDTH_ADR'(1);
            end
            if (issue && is_write) din_hold_q <= cur_din;

            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        mode_q      <= MODE;
                        seed_q      <= SEED;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        head_err_q  <= 1'b0;
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_CHECK_HEAD;
                    end
                end
                S_CHECK_HEAD: begin
                    addr_q <= '0;
                    if (RAM_HEAD != EXP_HEAD) begin
                        head_err_q <= 1'b1;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_FINISH;
                    end else begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: if (issue && (&addr_q)) state_q <= S_READ;
                S_READ:  if (issue && (&addr_q)) state_q <= S_DRAIN;
                S_DRAIN: begin
                    // Result registers are loaded on entry so FINISH already shows them.
                    if (!pipe_busy) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0) && !head_err_q;
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skeleton_ram_driver.sv
// Scoreboard bench for skeleton_ram_driver: expected bus transactions and results are
// queued when a test is launched and compared as the DUT issues accesses and raises DONE.
module tb_skeleton_ram_driver;

    localparam logic [25:0] HEAD_GOOD = {4'd4, 6'd6, 6'd6, 5'd12, 5'd12};
    localparam logic [25:0] HEAD_BAD  = {4'd3, 6'd6, 6'd6, 5'd12, 5'd12};

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] seed = 12'd0;
    logic        rdy = 1'b1;
    logic [15:0] dout = 16'd0;
    logic [25:0] head = HEAD_GOOD;

    logic        ram_en, ram_rnw, busy, done, pass, head_err;
    logic [5:0]  ram_adr, first_err;
    logic [15:0] ram_din;
    logic [6:0]  err_cnt;

    always #5 clk = ~clk;

    skeleton_ram_driver dut (
        .CLK_SYS(clk), .RSTN(rstn), .START(start), .MODE(mode), .SEED(seed),
        .RAM_EN(ram_en), .RAM_RnW(ram_rnw), .RAM_ADR(ram_adr), .RAM_DIN(ram_din),
        .RAM_DOUT(dout), .RAM_RDY(rdy), .RAM_HEAD(head),
        .BUSY(busy), .DONE(done), .PASS(pass), .HEAD_ERR(head_err),
        .ERR_CNT(err_cnt), .FIRST_ERR_ADR(first_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fault = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pat(input logic [1:0] m, input logic [11:0] s, input logic [5:0] a);
        case (m)
            2'd0:    return {6'b0, a};
            2'd1:    return ~{6'b0, a};
            2'd2:    return a[0] ? 12'h555 : 12'hAAA;
            default: return s + {6'b0, a};
        endcase
    endfunction

    // Behavioural skeleton RAM, 1-cycle read, with optional planted data faults.
    logic [15:0] mem [64];
    function automatic logic [15:0] corrupt(input logic [15:0] w, input logic [5:0] a);
        logic [15:0] r;
        r = w;
        if (fault == 1) r[15] = 1'b0;
        if (fault == 2 && a == 6'd37) r[4] = ~r[4];
        if (fault == 3 && a == 6'd10) r[0] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_rnw) mem[ram_adr] <= ram_din;
            else         dout <= corrupt(mem[ram_adr], ram_adr);
        end
    end

    typedef struct packed {
        logic        rnw;
        logic [5:0]  adr;
        logic [15:0] din;
    } txn_t;

    typedef struct {
        int         cyc;
        logic       pass;
        logic       head;
        logic [6:0] cnt;
        logic [5:0] first;
    } res_t;

    txn_t txq[$];
    res_t rq[$];

    always @(negedge clk) begin : monitor
        txn_t t;
        if (ram_en === 1'b1) begin
            check("en_rdy", rdy, 1'b1);
            check("en_expected", txq.size() != 0, 1'b1);
            if (txq.size() != 0) begin
                t = txq.pop_front();
                check("rnw", ram_rnw, t.rnw);
                check("adr", ram_adr, t.adr);
                if (t.rnw) check("din", ram_din, t.din);
            end
        end
    end

    task automatic push_txns(input logic [1:0] m, input logic [11:0] s);
        for (int i = 0; i < 64; i++) txq.push_back(txn_t'{1'b1, 6'(i), {pat(m, s, 6'(i)), 4'h0}});
        for (int i = 0; i < 64; i++) txq.push_back(txn_t'{1'b0, 6'(i), 16'h0});
    endtask

    task automatic kick();
        @(posedge clk); #1 start = 1'b1; rdy = 1'b1;
        @(posedge clk); #1 start = 1'b0; cyc = 1;
    endtask

    task automatic wait_done(input bit throttle, input int poke, output int dc);
        dc = -1;
        while (cyc < 1000) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
            check("busy", busy, 1'b1);
            @(posedge clk); #1;
            cyc++;
            rdy   = throttle ? 1'(cyc % 2) : 1'b1;
            start = (cyc == poke);
        end
        start = 1'b0;
        rdy   = 1'b1;
    endtask

    task automatic run_test(input string name, input logic [1:0] m, input logic [11:0] s,
                            input int f, input bit thr, input int poke, input bit bad_head,
                            input int ecyc, input bit epass, input logic [6:0] ecnt,
                            input logic [5:0] efirst);
        res_t e;
        int   dc;
        mode  = m;
        seed  = s;
        fault = f;
        head  = bad_head ? HEAD_BAD : HEAD_GOOD;
        if (!bad_head) push_txns(m, s);
        rq.push_back(res_t'{ecyc, epass, bad_head, ecnt, efirst});
        kick();
        wait_done(thr, poke, dc);
        e = rq.pop_front();
        check({name, "_done_cyc"}, dc, e.cyc);
        check({name, "_pass"}, pass, e.pass);
        check({name, "_head_err"}, head_err, e.head);
        check({name, "_err_cnt"}, err_cnt, e.cnt);
        check({name, "_first_err"}, first_err, e.first);
        check({name, "_busy_low"}, busy, 1'b0);
        check({name, "_txn_left"}, txq.size(), 0);
        txq.delete();
        head  = HEAD_GOOD;
        fault = 0;
    endtask

    initial begin : main
        bit found;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {busy, done, pass, head_err, err_cnt, first_err,
                             ram_en, ram_rnw, ram_adr, ram_din}, 0);
        rstn = 1'b1;

        run_test("ideal",      2'd0, 12'h000, 0, 1'b0, 0, 1'b0, 131, 1'b1, 7'd0,  6'd0);
        run_test("stuck15",    2'd1, 12'h000, 1, 1'b0, 0, 1'b0, 131, 1'b0, 7'd64, 6'd0);
        run_test("flip37",     2'd3, 12'hFF0, 2, 1'b0, 0, 1'b0, 131, 1'b0, 7'd1,  6'd37);
        run_test("lsb10",      2'd0, 12'h000, 3, 1'b0, 0, 1'b0, 131, 1'b0, 7'd1,  6'd10);
        run_test("rdy_toggle", 2'd2, 12'h000, 0, 1'b1, 0, 1'b0, 259, 1'b1, 7'd0,  6'd0);
        run_test("bad_head",   2'd0, 12'h000, 0, 1'b0, 0, 1'b1, 2,   1'b0, 7'd0,  6'd0);

        // Abort mid-read with reset, then confirm a clean rerun that also ignores a START while busy.
        mode = 2'd0;
        seed = 12'h000;
        push_txns(2'd0, 12'h000);
        kick();
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (ram_en && !ram_rnw && ram_adr == 6'd20) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rst_reach_adr20", found, 1'b1);
        rstn = 1'b0;
        #1;
        check("rst_outs", {busy, done, pass, head_err, err_cnt, first_err,
                           ram_en, ram_rnw, ram_adr, ram_din}, 0);
        txq.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_no_en", ram_en, 1'b0);
        end
        @(posedge clk); #1 rstn = 1'b1;

        run_test("rerun_poke", 2'd3, 12'h123, 0, 1'b0, 40, 1'b0, 131, 1'b1, 7'd0, 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
